// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//   Boot-time sequencer sitting between the RS-232 receiver and the
//   instruction memory. Received bytes are packed MSB-first into 32-bit words
//   and written to consecutive imem addresses starting at 0. When the
//   END_MARKER word arrives, loading stops and the CPU is released. From then
//   on every received byte is forwarded to the CPU input path.
//
// Ports
//   clk, reset    system clock, synchronous active-high reset
//   rx_data       received byte, qualified by rx_changed
//   rx_changed    one-cycle strobe per received byte (may be back-to-back)
//   imem_we       one-cycle write strobe per stored word
//   imem_addr     write address; holds the last written address otherwise
//   imem_wdata    write data (meaningful only while imem_we=1)
//   cpu_start     level, 1 once the end marker has been accepted
//   load_done     one-cycle pulse when the end marker is accepted
//   words_loaded  number of words written to imem
//   overflow      sticky, a data word arrived while imem was full
//   fwd_data      byte forwarded to the CPU input path
//   fwd_valid     one-cycle strobe qualifying fwd_data
//   dbg_state     current FSM state (0 = LOAD, 1 = RUN)
//
// Handshake: rx_changed is a pure strobe with no back-pressure; a byte is
// consumed on every clock edge where rx_changed=1. imem_we and fwd_valid are
// likewise single-cycle strobes with no ready signal on the receiving side.
// ---------------------------------------------------------------------------
module program_loader #(
    parameter int          ADDR_W     = 12,
    parameter int          MEM_DEPTH  = 4096,
    parameter logic [31:0] END_MARKER = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_changed,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_start,
    output logic              load_done,
    output logic [ADDR_W:0]   words_loaded,
    output logic              overflow,
    output logic [7:0]        fwd_data,
    output logic              fwd_valid,
    output logic              dbg_state
);

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);

    state_t              state_q, state_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [23:0]         shift_q, shift_d;     // first three bytes of the word
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                start_q, start_d;
    logic                done_q, done_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                ovf_q, ovf_d;
    logic [7:0]          fwd_data_q, fwd_data_d;
    logic                fwd_valid_q, fwd_valid_d;
    logic [31:0]         word;

    // The word completes with the byte currently on rx_data.
    assign word = {shift_q, rx_data};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= LOAD;
            byte_cnt_q  <= '0;
            shift_q     <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            fwd_data_q  <= '0;
            fwd_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            start_q     <= start_d;
            done_q      <= done_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            fwd_data_q  <= fwd_data_d;
            fwd_valid_q <= fwd_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        start_d     = start_q;
        done_d      = 1'b0;
        count_d     = count_q;
        ovf_d       = ovf_q;
        fwd_data_d  = fwd_data_q;
        fwd_valid_d = 1'b0;

        case (state_q)
            LOAD: begin
                if (rx_changed) begin
                    shift_d    = {shift_q[15:0], rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (word == END_MARKER) begin
                            state_d    = RUN;
                            start_d    = 1'b1;
                            done_d     = 1'b1;
                            byte_cnt_d = '0;
                        end else if (count_q < DEPTH) begin
                            // The word count doubles as the next free address.
                            we_d    = 1'b1;
                            wdata_d = word;
                            addr_d  = count_q[ADDR_W-1:0];
                            count_d = count_q + 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end
            end
            RUN: begin
                if (rx_changed) begin
                    fwd_valid_d = 1'b1;
                    fwd_data_d  = rx_data;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign cpu_start    = start_q;
    assign load_done    = done_q;
    assign words_loaded = count_q;
    assign overflow     = ovf_q;
    assign fwd_data     = fwd_data_q;
    assign fwd_valid    = fwd_valid_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        rx_data = '0;
  logic              rx_changed = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_start;
  logic              load_done;
  logic [ADDR_W:0]   words_loaded;
  logic              overflow;
  logic [7:0]        fwd_data;
  logic              fwd_valid;
  logic              dbg_state;

  always #5 clk = ~clk;

  program_loader #(.ADDR_W(ADDR_W), .MEM_DEPTH(DEPTH), .END_MARKER(32'hFFFF_FFFF)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_changed(rx_changed),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_start(cpu_start), .load_done(load_done), .words_loaded(words_loaded),
    .overflow(overflow), .fwd_data(fwd_data), .fwd_valid(fwd_valid),
    .dbg_state(dbg_state)
  );

  // ---------------- monitor (write / forward logs) ----------------
  int          cyc = 0;
  int          wr_n = 0;
  int          fwd_n = 0;
  int          done_n = 0;
  logic [ADDR_W-1:0] wr_addr [0:63];
  logic [31:0]       wr_data [0:63];
  int                wr_cyc  [0:63];
  logic [7:0]        fwd_log [0:63];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (imem_we && wr_n < 64) begin
      wr_addr[wr_n] = imem_addr;
      wr_data[wr_n] = imem_wdata;
      wr_cyc[wr_n]  = cyc;
      wr_n++;
    end
    if (fwd_valid && fwd_n < 64) begin
      fwd_log[fwd_n] = fwd_data;
      fwd_n++;
    end
    if (load_done) done_n++;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  int wr_rd = 0;
  int fwd_rd = 0;
  logic [ADDR_W+31:0] exp_q[$];
  logic [7:0]         exp_fwd_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compares every logged write since the last call against exp_q, in order.
  task automatic drain_writes(input string tag);
    logic [ADDR_W+31:0] e;
    #2;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (wr_rd < wr_n) begin
        check({tag, "_wr"}, {wr_addr[wr_rd], wr_data[wr_rd]}, e);
        wr_rd++;
      end else begin
        check({tag, "_wr_missing"}, 64'h0, e);
      end
    end
    check({tag, "_no_extra_wr"}, wr_n, wr_rd);
    wr_rd = wr_n;
  endtask

  task automatic drain_fwd(input string tag);
    logic [7:0] e;
    #2;
    while (exp_fwd_q.size() > 0) begin
      e = exp_fwd_q.pop_front();
      if (fwd_rd < fwd_n) begin
        check({tag, "_fwd"}, fwd_log[fwd_rd], e);
        fwd_rd++;
      end else begin
        check({tag, "_fwd_missing"}, 64'h0, e);
      end
    end
    check({tag, "_no_extra_fwd"}, fwd_n, fwd_rd);
    fwd_rd = fwd_n;
  endtask

  // ---------------- driver tasks ----------------
  // One strobe followed by an idle cycle; returns at the negedge where the
  // registered response to this byte is visible.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data    = b;
    rx_changed = 1'b1;
    @(negedge clk);
    rx_changed = 1'b0;
    rx_data    = '0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  logic [7:0] burst [0:12];
  int         d0;

  initial begin
    // ---- reset state ----
    do_reset(2);
    check("rst_we", imem_we, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_cpu_start", cpu_start, 0);
    check("rst_load_done", load_done, 0);
    check("rst_words", words_loaded, 0);
    check("rst_overflow", overflow, 0);
    check("rst_fwd_valid", fwd_valid, 0);
    check("rst_state", dbg_state, 0);

    // ---- test 1: two words then marker ----
    send_word(32'h1234_5678);
    check("t1_we_w0", imem_we, 1);
    check("t1_addr_w0", imem_addr, 0);
    check("t1_data_w0", imem_wdata, 32'h1234_5678);
    @(negedge clk);
    check("t1_we_one_cycle", imem_we, 0);
    check("t1_addr_hold", imem_addr, 0);
    send_word(32'hDEAD_BEEF);
    check("t1_we_w1", imem_we, 1);
    check("t1_addr_w1", imem_addr, 1);
    check("t1_data_w1", imem_wdata, 32'hDEAD_BEEF);
    check("t1_words_2", words_loaded, 2);
    d0 = done_n;
    send_word(32'hFFFF_FFFF);
    check("t1_done_pulse", load_done, 1);
    check("t1_cpu_start", cpu_start, 1);
    check("t1_marker_no_we", imem_we, 0);
    @(negedge clk);
    check("t1_done_drop", load_done, 0);
    check("t1_cpu_start_hold", cpu_start, 1);
    check("t1_state_run", dbg_state, 1);
    #2;
    check("t1_done_count", done_n - d0, 1);
    exp_q.push_back({12'd0, 32'h1234_5678});
    exp_q.push_back({12'd1, 32'hDEAD_BEEF});
    drain_writes("t1");

    // ---- test 2: forwarding in RUN ----
    send_byte(8'h00);
    check("t2_fwd_valid0", fwd_valid, 1);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h0A);
    check("t2_fwd_valid3", fwd_valid, 1);
    check("t2_fwd_data3", fwd_data, 8'h0A);
    check("t2_no_we", imem_we, 0);
    @(negedge clk);
    check("t2_fwd_drop", fwd_valid, 0);
    check("t2_words_hold", words_loaded, 2);
    check("t2_cpu_start", cpu_start, 1);
    exp_fwd_q.push_back(8'h00);
    exp_fwd_q.push_back(8'h00);
    exp_fwd_q.push_back(8'h00);
    exp_fwd_q.push_back(8'h0A);
    drain_fwd("t2");
    drain_writes("t2");

    // ---- test 6: reset while in RUN ----
    do_reset(1);
    check("t6_cpu_start_drop", cpu_start, 0);
    check("t6_words_clear", words_loaded, 0);
    check("t6_state_load", dbg_state, 0);

    // ---- test 4: reset mid-word discards partial bytes ----
    send_byte(8'hAA);
    send_byte(8'hBB);
    do_reset(1);
    send_word(32'h0102_0304);
    check("t4_we", imem_we, 1);
    check("t4_addr", imem_addr, 0);
    check("t4_data", imem_wdata, 32'h0102_0304);
    send_word(32'hFFFF_FFFF);
    check("t4_cpu_start", cpu_start, 1);
    check("t4_words_1", words_loaded, 1);
    exp_q.push_back({12'd0, 32'h0102_0304});
    drain_writes("t4");

    // ---- test 5: back-to-back strobes, marker, byte in transition cycle ----
    do_reset(1);
    for (int i = 0; i < 8; i++) burst[i] = 8'(i);
    for (int i = 8; i < 12; i++) burst[i] = 8'hFF;
    burst[12] = 8'h55;
    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      rx_data    = burst[i];
      rx_changed = 1'b1;
      @(negedge clk);
    end
    rx_changed = 1'b0;
    rx_data    = '0;
    @(negedge clk);
    exp_q.push_back({12'd0, 32'h0001_0203});
    exp_q.push_back({12'd1, 32'h0405_0607});
    drain_writes("t5");
    if (wr_n >= 2) check("t5_spacing", wr_cyc[wr_n-1] - wr_cyc[wr_n-2], 4);
    else check("t5_spacing_missing", wr_n, 2);
    check("t5_cpu_start", cpu_start, 1);
    check("t5_words_2", words_loaded, 2);
    exp_fwd_q.push_back(8'h55);
    drain_fwd("t5");

    // ---- test 3: overflow with MEM_DEPTH=4 ----
    do_reset(1);
    for (int i = 1; i <= 4; i++) begin
      send_word(32'(i) * 32'h0101_0101);
      exp_q.push_back({12'(i - 1), 32'(i) * 32'h0101_0101});
    end
    check("t3_no_ovf_yet", overflow, 0);
    check("t3_words_4", words_loaded, 4);
    send_word(32'h0505_0505);
    check("t3_ovf_no_we", imem_we, 0);
    check("t3_ovf_set", overflow, 1);
    check("t3_addr_hold", imem_addr, 3);
    check("t3_words_hold", words_loaded, 4);
    send_word(32'hFFFF_FFFF);
    check("t3_cpu_start", cpu_start, 1);
    check("t3_ovf_sticky", overflow, 1);
    drain_writes("t3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
